// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg
// Shared definitions for the register-file writeback arbiter and its queue.
//   REG_AW        : register address width (32 architectural registers)
//   XLEN_DEFAULT  : default data width
//   NUM_REGS      : number of architectural registers
//   rf_wb_entry_t : one queued long-path write {valid, wa, wd} at default width
//   reg_onehot    : one-hot decode of a register address
package rf_wb_pkg;

    localparam int REG_AW       = 5;
    localparam int XLEN_DEFAULT = 32;
    localparam int NUM_REGS     = 32;

    typedef struct packed {
        logic                    valid;
        logic [REG_AW-1:0]       wa;
        logic [XLEN_DEFAULT-1:0] wd;
    } rf_wb_entry_t;

    // One-hot decode of a register address, used to build per-register masks.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] wa);
        logic [NUM_REGS-1:0] mask;
        mask     = '0;
        mask[wa] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rf_wb_queue.sv
// rf_wb_queue
// Circular FIFO for long-latency writeback results, with an address-match kill.
// A kill clears the valid bit of every occupied entry whose address matches,
// including an entry being pushed in the same cycle. Entries pushed to x0 are
// stored invalid. Popped entries have their valid bit cleared so that the
// valid vector only ever reflects occupied slots.
// Optional build macro: RF_WB_PENDING_EN exports per-entry valid/address.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_push, i_push_wa/wd push request (caller gates with !o_full) and payload
//   i_pop               pop request (ignored when empty)
//   i_kill_en/i_kill_wa invalidate matching entries
//   o_full, o_empty     occupancy flags
//   o_head_valid/wa/wd  head entry (o_head_valid is 0 when empty)
//   o_ent_valid/o_ent_wa per-entry state (RF_WB_PENDING_EN only)
module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [REG_AW-1:0]       i_push_wa,
    input  logic [XLEN-1:0]         i_push_wd,
    input  logic                    i_pop,
    input  logic                    i_kill_en,
    input  logic [REG_AW-1:0]       i_kill_wa,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_head_valid,
    output logic [REG_AW-1:0]       o_head_wa,
    output logic [XLEN-1:0]         o_head_wd
`ifdef RF_WB_PENDING_EN
    ,
    output logic [DEPTH-1:0]        o_ent_valid,
    output logic [DEPTH*REG_AW-1:0] o_ent_wa
`endif
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]        r_wr_ptr;
    logic [PW:0]        r_rd_ptr;
    logic [DEPTH-1:0]   r_valid;
    logic [REG_AW-1:0]  r_wa [DEPTH];
    logic [XLEN-1:0]    r_wd [DEPTH];

    logic [PW-1:0]      w_wr_idx;
    logic [PW-1:0]      w_rd_idx;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_push_live;
    logic [DEPTH-1:0]   w_match;

    assign w_wr_idx  = r_wr_ptr[PW-1:0];
    assign w_rd_idx  = r_rd_ptr[PW-1:0];
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (w_wr_idx == w_rd_idx) && (r_wr_ptr[PW] != r_rd_ptr[PW]);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // A newly pushed entry is dead on arrival if it targets x0 or is killed
    // by an ALU write to the same register in the same cycle.
    assign w_push_live = (i_push_wa != '0) && !(i_kill_en && (i_kill_wa == i_push_wa));

    assign o_head_valid = !o_empty && r_valid[w_rd_idx];
    assign o_head_wa    = r_wa[w_rd_idx];
    assign o_head_wd    = r_wd[w_rd_idx];

    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i] && i_kill_en && (r_wa[i] == i_kill_wa);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // The push slot can never be the pop slot: a push needs !full and a pop
    // needs !empty, so equal indices would mean an empty queue with no pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push_ok && (w_wr_idx == PW'(i))) begin
                    r_valid[i] <= w_push_live;
                end else if ((w_pop_ok && (w_rd_idx == PW'(i))) || w_match[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_wa[w_wr_idx] <= i_push_wa;
            r_wd[w_wr_idx] <= i_push_wd;
        end
    end

`ifdef RF_WB_PENDING_EN
    assign o_ent_valid = r_valid;
    always_comb begin
        o_ent_wa = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_wa[i*REG_AW +: REG_AW] = r_wa[i];
        end
    end
`endif

endmodule

// File: rtl/rf_writeback_arb.sv
// rf_writeback_arb
// Arbitrates the single register-file write port between single-cycle ALU
// results (always win, no backpressure) and long-latency results buffered in
// rf_wb_queue. Writes to x0 never reach rf_we. An accepted ALU write kills
// queued writes to the same register, since the ALU result is younger.
// Optional build macro: RF_WB_PENDING_EN adds the 'pending' scoreboard output.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_we/alu_wa/alu_wd       ALU write
//   lu_valid/lu_ready/lu_wa/lu_wd  long-path write handshake
//   rf_we/rf_wa/rf_wd          registered register-file write port
//   byp_ra1/2, byp_hit1/2, byp_data1/2  bypass of the in-flight write
//   pending                    per-register outstanding write (RF_WB_PENDING_EN)
module rf_writeback_arb
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_we,
    input  logic [REG_AW-1:0]   alu_wa,
    input  logic [XLEN-1:0]     alu_wd,
    input  logic                lu_valid,
    output logic                lu_ready,
    input  logic [REG_AW-1:0]   lu_wa,
    input  logic [XLEN-1:0]     lu_wd,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_wa,
    output logic [XLEN-1:0]     rf_wd,
    input  logic [REG_AW-1:0]   byp_ra1,
    input  logic [REG_AW-1:0]   byp_ra2,
    output logic                byp_hit1,
    output logic                byp_hit2,
    output logic [XLEN-1:0]     byp_data1,
    output logic [XLEN-1:0]     byp_data2
`ifdef RF_WB_PENDING_EN
    ,
    output logic [NUM_REGS-1:0] pending
`endif
);

    logic                r_rf_we;
    logic [REG_AW-1:0]   r_rf_wa;
    logic [XLEN-1:0]     r_rf_wd;

    logic                w_alu_win;
    logic                w_push;
    logic                w_pop;
    logic                w_q_full;
    logic                w_q_empty;
    logic                w_head_valid;
    logic [REG_AW-1:0]   w_head_wa;
    logic [XLEN-1:0]     w_head_wd;
`ifdef RF_WB_PENDING_EN
    logic [DEPTH-1:0]        w_ent_valid;
    logic [DEPTH*REG_AW-1:0] w_ent_wa;
`endif

    // An ALU write to x0 is a no-op, so it neither wins the port nor kills.
    assign w_alu_win = alu_we && (alu_wa != '0);
    assign lu_ready  = !w_q_full;
    assign w_push    = lu_valid && lu_ready;
    assign w_pop     = !w_alu_win && !w_q_empty;

    rf_wb_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_wa    (lu_wa),
        .i_push_wd    (lu_wd),
        .i_pop        (w_pop),
        .i_kill_en    (w_alu_win),
        .i_kill_wa    (alu_wa),
        .o_full       (w_q_full),
        .o_empty      (w_q_empty),
        .o_head_valid (w_head_valid),
        .o_head_wa    (w_head_wa),
        .o_head_wd    (w_head_wd)
`ifdef RF_WB_PENDING_EN
        ,
        .o_ent_valid  (w_ent_valid),
        .o_ent_wa     (w_ent_wa)
`endif
    );

    // Output stage: the address/data hold their last value when idle; only
    // rf_we qualifies them. An invalid (killed or x0) head pops as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we <= 1'b0;
            r_rf_wa <= '0;
            r_rf_wd <= '0;
        end else if (w_alu_win) begin
            r_rf_we <= 1'b1;
            r_rf_wa <= alu_wa;
            r_rf_wd <= alu_wd;
        end else if (w_pop && w_head_valid) begin
            r_rf_we <= 1'b1;
            r_rf_wa <= w_head_wa;
            r_rf_wd <= w_head_wd;
        end else begin
            r_rf_we <= 1'b0;
        end
    end

    assign rf_we     = r_rf_we;
    assign rf_wa     = r_rf_wa;
    assign rf_wd     = r_rf_wd;

    assign byp_hit1  = r_rf_we && (byp_ra1 == r_rf_wa);
    assign byp_hit2  = r_rf_we && (byp_ra2 == r_rf_wa);
    assign byp_data1 = r_rf_wd;
    assign byp_data2 = r_rf_wd;

`ifdef RF_WB_PENDING_EN
    // x0 is masked explicitly even though no valid entry can target it.
    always_comb begin
        pending = '0;
        if (r_rf_we) pending = pending | reg_onehot(r_rf_wa);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i]) pending = pending | reg_onehot(w_ent_wa[i*REG_AW +: REG_AW]);
        end
        pending[0] = 1'b0;
    end
`endif

endmodule
